// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared mode encodings, BCD limits and BCD helper for the time counter
//
// Purpose : common definitions for clock_time_counter and bcd_mod_counter.
// Ports   : none (package).
// Config  : ALARM_EN (consumed by clock_time_counter) enables the alarm modes 3/4.

package clock_pkg;

   localparam int BCD_W = 8;

   typedef enum logic [2:0] {
      MODE_RUN        = 3'd0,
      MODE_SET_HR     = 3'd1,
      MODE_SET_MIN    = 3'd2,
      MODE_SET_AL_HR  = 3'd3,
      MODE_SET_AL_MIN = 3'd4
   } mode_e;

   localparam logic [BCD_W-1:0] SEC_MAX = 8'h59;
   localparam logic [BCD_W-1:0] MIN_MAX = 8'h59;
   localparam logic [BCD_W-1:0] HR_MAX  = 8'h23;

   // Two-digit BCD increment; units 9 rolls into the tens digit.
   // Wrapping at the field limit is handled by the caller.
   function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      if (v[3:0] == 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter wrapping at MAX back to 00
//
// Purpose : one time field (seconds, minutes, hours, alarm hours/minutes).
// Ports   : clk   - system clock
//           rst   - asynchronous active-high reset, value -> 00
//           clr   - synchronous clear to 00 (wins over inc)
//           inc   - advance by one, MAX wraps to 00
//           value - {tens, units} BCD
//           carry - value==MAX while inc is high (wrap about to happen)

import clock_pkg::*;

module bcd_mod_counter #(
   parameter logic [BCD_W-1:0] MAX = 8'h59
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [BCD_W-1:0] value,
   output logic             carry
);

   assign carry = inc & (value == MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc) begin
         value <= (value == MAX) ? '0 : bcd_inc(value);
      end
   end

endmodule

// File: rtl/clock_time_counter.sv
// rtl/clock_time_counter.sv - 24 h BCD timekeeper with hour/minute set mode and optional alarm
//
// Purpose : prescale the divider square wave to 1 Hz and keep hh:mm:ss in BCD.
// Ports   : clk       - system clock
//           rst       - asynchronous active-high reset
//           tick_in   - divider output level (already in clk domain)
//           btn_mode  - one-cycle pulse, advance mode
//           btn_inc   - one-cycle pulse, increment selected field / silence alarm
//           sec_bcd   - seconds BCD 00..59
//           min_bcd   - minutes BCD 00..59
//           hr_bcd    - hours BCD 00..23
//           mode      - 0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_AL_HR, 4 SET_AL_MIN
//           sec_pulse - one-cycle strobe per seconds increment
//           alarm_out - alarm active
// Config  : `define ALARM_EN adds alarm registers and modes 3/4; otherwise alarm_out is 0.

import clock_pkg::*;

module clock_time_counter #(
   parameter int TICKS_PER_SEC = 200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_in,
   input  logic             btn_mode,
   input  logic             btn_inc,
   output logic [BCD_W-1:0] sec_bcd,
   output logic [BCD_W-1:0] min_bcd,
   output logic [BCD_W-1:0] hr_bcd,
   output logic [2:0]       mode,
   output logic             sec_pulse,
   output logic             alarm_out
);

   localparam int            PW       = $clog2(TICKS_PER_SEC) + 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

   mode_e         state, state_nxt;
   logic          tick_q;
   logic [PW-1:0] pre_cnt;
   logic          is_run, edge_det, run_tick, set_inc;
   logic          sec_inc, sec_clr, sec_carry;
   logic          min_inc, min_carry;
   logic          hr_inc, unused_hr_carry;

   // ---------------- mode FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= MODE_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (btn_mode) begin
         case (state)
            MODE_RUN:        state_nxt = MODE_SET_HR;
            MODE_SET_HR:     state_nxt = MODE_SET_MIN;
`ifdef ALARM_EN
            MODE_SET_MIN:    state_nxt = MODE_SET_AL_HR;
            MODE_SET_AL_HR:  state_nxt = MODE_SET_AL_MIN;
            MODE_SET_AL_MIN: state_nxt = MODE_RUN;
`else
            MODE_SET_MIN:    state_nxt = MODE_RUN;
`endif
            default:         state_nxt = MODE_RUN;
         endcase
      end
   end

   always_comb begin
      mode    = state;
      is_run  = (state == MODE_RUN);
      // btn_mode takes priority: a coincident increment is dropped
      set_inc = btn_inc & ~btn_mode;
   end

   // ---------------- tick edge detect and prescaler ----------------
   assign edge_det = tick_in & ~tick_q;
   // The cycle that leaves RUN does not count, so the seconds clear cleanly.
   assign run_tick = is_run & ~btn_mode & edge_det;
   assign sec_inc  = run_tick & (pre_cnt == PRE_LAST);
   assign sec_clr  = is_run & btn_mode;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_q    <= 1'b0;
         sec_pulse <= 1'b0;
      end else begin
         tick_q    <= tick_in;
         sec_pulse <= sec_inc;
      end
   end

   // Held at 0 outside RUN so a return to RUN restarts a full second.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt <= '0;
      end else if (!is_run || btn_mode) begin
         pre_cnt <= '0;
      end else if (edge_det) begin
         pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
      end
   end

   // ---------------- time fields ----------------
   // Carries only ripple in RUN; set-mode increments stay within one field.
   assign min_inc = sec_carry | ((state == MODE_SET_MIN) & set_inc);
   assign hr_inc  = (min_carry & is_run) | ((state == MODE_SET_HR) & set_inc);

   bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
      .clk(clk), .rst(rst), .clr(sec_clr), .inc(sec_inc),
      .value(sec_bcd), .carry(sec_carry)
   );

   bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
      .clk(clk), .rst(rst), .clr(1'b0), .inc(min_inc),
      .value(min_bcd), .carry(min_carry)
   );

   bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
      .clk(clk), .rst(rst), .clr(1'b0), .inc(hr_inc),
      .value(hr_bcd), .carry(unused_hr_carry)
   );

   // ---------------- alarm ----------------
`ifdef ALARM_EN
   logic [BCD_W-1:0] al_hr, al_min;
   logic             silence, unused_al_hr_carry, unused_al_min_carry;

   bcd_mod_counter #(.MAX(HR_MAX)) u_al_hr (
      .clk(clk), .rst(rst), .clr(1'b0),
      .inc((state == MODE_SET_AL_HR) & set_inc),
      .value(al_hr), .carry(unused_al_hr_carry)
   );

   bcd_mod_counter #(.MAX(MIN_MAX)) u_al_min (
      .clk(clk), .rst(rst), .clr(1'b0),
      .inc((state == MODE_SET_AL_MIN) & set_inc),
      .value(al_min), .carry(unused_al_min_carry)
   );

   assign alarm_out = is_run & (hr_bcd == al_hr) & (min_bcd == al_min) & ~silence;

   // Silence lasts until the minute moves on, re-arming the alarm for the next day.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         silence <= 1'b0;
      end else if (min_inc) begin
         silence <= 1'b0;
      end else if (alarm_out & set_inc) begin
         silence <= 1'b1;
      end
   end
`else
   assign alarm_out = 1'b0;
`endif

endmodule
